// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants for the multi-port register file
package regfile_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;
endpackage

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one combinational read port: zero-register,
// write bypass and busy-flag selection.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0]     rn_i,
    input  logic [DATA_W-1:0]     mem_i [2**ADDR_W],
    input  logic [2**ADDR_W-1:0]  busy_i,
    input  logic                  w0_valid_i,
    input  logic [ADDR_W-1:0]     wn0_i,
    input  logic [DATA_W-1:0]     d0_i,
    input  logic                  w1_valid_i,
    input  logic [ADDR_W-1:0]     wn1_i,
    input  logic [DATA_W-1:0]     d1_i,
    input  logic                  iss_valid_i,
    input  logic [ADDR_W-1:0]     iss_rn_i,
    output logic [DATA_W-1:0]     q_o,
    output logic                  rbusy_o
);
    logic is_zero;
    logic hit0;
    logic hit1;
    logic iss_hit;

    assign is_zero = (ZERO_REG != 0) && (rn_i == ADDR_W'(REG_ZERO));
    assign hit0    = (BYPASS != 0) && w0_valid_i && (wn0_i == rn_i);
    assign hit1    = (BYPASS != 0) && w1_valid_i && (wn1_i == rn_i);
    assign iss_hit = iss_valid_i && (iss_rn_i == rn_i);

    // Port 1 (load writeback) outranks port 0 on a same-register collision.
    always_comb begin
        q_o     = mem_i[rn_i];
        rbusy_o = busy_i[rn_i];
        if (is_zero) begin
            q_o     = '0;
            rbusy_o = 1'b0;
        end else begin
            if (hit1) begin
                q_o = d1_i;
            end else if (hit0) begin
                q_o = d0_i;
            end
            if ((hit0 || hit1) && !iss_hit) begin
                rbusy_o = 1'b0;
            end
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - NREAD-read / 2-write register file with optional
// write bypass and a per-register busy scoreboard for load-use interlock.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [NREAD*ADDR_W-1:0]  rn,
    output logic [NREAD*DATA_W-1:0]  q,
    output logic [NREAD-1:0]         rbusy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wn0,
    input  logic [DATA_W-1:0]        d0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wn1,
    input  logic [DATA_W-1:0]        d1,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_rn
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              w0_valid;
    logic              w1_valid;
    logic              iss_valid;

    assign w0_valid  = we0    && ((ZERO_REG == 0) || (wn0    != ADDR_W'(REG_ZERO)));
    assign w1_valid  = we1    && ((ZERO_REG == 0) || (wn1    != ADDR_W'(REG_ZERO)));
    assign iss_valid = iss_en && ((ZERO_REG == 0) || (iss_rn != ADDR_W'(REG_ZERO)));

    // A fresh issue outranks a retiring write: the newer producer is pending.
    always_comb begin
        busy_d = busy_q;
        if (w0_valid) busy_d[wn0] = 1'b0;
        if (w1_valid) busy_d[wn1] = 1'b0;
        if (iss_valid) busy_d[iss_rn] = 1'b1;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (w0_valid) mem_q[wn0] <= d0;
            if (w1_valid) mem_q[wn1] <= d1;
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [DATA_W-1:0] rd_q;
        logic              rd_busy;

        regfile_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rdport (
            .rn_i        (rn[k*ADDR_W +: ADDR_W]),
            .mem_i       (mem_q),
            .busy_i      (busy_q),
            .w0_valid_i  (w0_valid),
            .wn0_i       (wn0),
            .d0_i        (d0),
            .w1_valid_i  (w1_valid),
            .wn1_i       (wn1),
            .d1_i        (d1),
            .iss_valid_i (iss_valid),
            .iss_rn_i    (iss_rn),
            .q_o         (rd_q),
            .rbusy_o     (rd_busy)
        );

        // Bypass paths must not leak data while reset is held.
        assign q[k*DATA_W +: DATA_W] = clr ? '0 : rd_q;
        assign rbusy[k]              = ~clr & rd_busy;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed vectors on default and no-bypass builds,
// plus a reference-model run on a 4-read, 64-entry build.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [9:0]  rn;
    logic [63:0] qa, qb;
    logic [1:0]  rba, rbb;
    logic        we0, we1, iss_en;
    logic [4:0]  wn0, wn1, iss_rn;
    logic [31:0] d0, d1;

    logic [23:0]  c_rn;
    logic [127:0] c_q;
    logic [3:0]   c_rbusy;
    logic         c_we0, c_we1, c_iss_en;
    logic [5:0]   c_wn0, c_wn1, c_iss_rn;
    logic [31:0]  c_d0, c_d1;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_mp u_dut_a (
        .clk(clk), .clr(clr), .rn(rn), .q(qa), .rbusy(rba),
        .we0(we0), .wn0(wn0), .d0(d0), .we1(we1), .wn1(wn1), .d1(d1),
        .iss_en(iss_en), .iss_rn(iss_rn)
    );

    regfile_mp #(.BYPASS(0)) u_dut_b (
        .clk(clk), .clr(clr), .rn(rn), .q(qb), .rbusy(rbb),
        .we0(we0), .wn0(wn0), .d0(d0), .we1(we1), .wn1(wn1), .d1(d1),
        .iss_en(iss_en), .iss_rn(iss_rn)
    );

    regfile_mp #(.NREAD(4), .ADDR_W(6)) u_dut_c (
        .clk(clk), .clr(clr), .rn(c_rn), .q(c_q), .rbusy(c_rbusy),
        .we0(c_we0), .wn0(c_wn0), .d0(c_d0), .we1(c_we1), .wn1(c_wn1), .d1(c_d1),
        .iss_en(c_iss_en), .iss_rn(c_iss_rn)
    );

    typedef struct {
        logic        we0;
        logic [4:0]  wn0;
        logic [31:0] d0;
        logic        we1;
        logic [4:0]  wn1;
        logic [31:0] d1;
        logic        iss;
        logic [4:0]  iss_rn;
        logic [4:0]  rn0, rn1;
        logic [31:0] eq0, eq1;
        logic        erb0, erb1;
        logic [31:0] eqb0;
        logic        erbb0;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(logic w0, logic [4:0] a0, logic [31:0] x0,
                                logic w1, logic [4:0] a1, logic [31:0] x1,
                                logic is, logic [4:0] ia, logic [4:0] r0, logic [4:0] r1,
                                logic [31:0] e0, logic [31:0] e1, logic b0, logic b1,
                                logic [31:0] eb0, logic bb0);
        vec_t v;
        v.we0 = w0; v.wn0 = a0; v.d0 = x0; v.we1 = w1; v.wn1 = a1; v.d1 = x1;
        v.iss = is; v.iss_rn = ia; v.rn0 = r0; v.rn1 = r1;
        v.eq0 = e0; v.eq1 = e1; v.erb0 = b0; v.erb1 = b1; v.eqb0 = eb0; v.erbb0 = bb0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        we0 = 0; wn0 = 0; d0 = 0; we1 = 0; wn1 = 0; d1 = 0; iss_en = 0; iss_rn = 0;
        c_we0 = 0; c_wn0 = 0; c_d0 = 0; c_we1 = 0; c_wn1 = 0; c_d1 = 0;
        c_iss_en = 0; c_iss_rn = 0; c_rn = '0;
    endtask

    function automatic logic [5:0] rnd_addr();
        return ($urandom % 2 == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
    endfunction

    logic [31:0] m_mem [64];
    logic [63:0] m_busy;

    initial begin
        idle();
        rn = '0;
        repeat (3) @(negedge clk);

        // Held reset: a write hitting the read address must not bypass.
        we0 = 1; wn0 = 5'd3; d0 = 32'h1234; rn = {5'd0, 5'd3};
        #1 chk("clr_bypass_q0", qa[31:0], 32'h0);
        idle();
        @(negedge clk);
        clr = 0;

        for (int i = 0; i < 32; i++) begin
            rn = {5'(31 - i), 5'(i)};
            #1;
            chk($sformatf("rst_q0[%0d]", i), qa[31:0], 32'h0);
            chk($sformatf("rst_q1[%0d]", 31 - i), qa[63:32], 32'h0);
            chk($sformatf("rst_rb[%0d]", i), {30'h0, rba}, 32'h0);
        end

        //        we0 wn0  d0            we1 wn1  d1            iss rn  rn0 rn1 eq0           eq1           rb0 rb1 eqb0          rbb0
        vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,             0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'h0,        0);
        vecs[1]  = mk(0, 0, 0,            0, 0, 0,             0, 0, 5, 0, 32'hDEADBEEF, 32'h0,        0, 0, 32'hDEADBEEF, 0);
        vecs[2]  = mk(1, 7, 32'h11,       1, 7, 32'h22,        0, 0, 7, 5, 32'h22,       32'hDEADBEEF, 0, 0, 32'h0,        0);
        vecs[3]  = mk(0, 0, 0,            0, 0, 0,             0, 0, 7, 5, 32'h22,       32'hDEADBEEF, 0, 0, 32'h22,       0);
        vecs[4]  = mk(0, 0, 0,            1, 0, 32'hFFFFFFFF,  1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0);
        vecs[5]  = mk(0, 0, 0,            0, 0, 0,             0, 0, 0, 7, 32'h0,        32'h22,       0, 0, 32'h0,        0);
        vecs[6]  = mk(0, 0, 0,            0, 0, 0,             1, 9, 9, 9, 32'h0,        32'h0,        0, 0, 32'h0,        0);
        vecs[7]  = mk(0, 0, 0,            0, 0, 0,             0, 0, 9, 7, 32'h0,        32'h22,       1, 0, 32'h0,        1);
        vecs[8]  = mk(0, 0, 0,            1, 9, 32'h99,        0, 0, 9, 7, 32'h99,       32'h22,       0, 0, 32'h0,        1);
        vecs[9]  = mk(0, 0, 0,            0, 0, 0,             0, 0, 9, 9, 32'h99,       32'h99,       0, 0, 32'h99,       0);
        vecs[10] = mk(1, 9, 32'hAA,       0, 0, 0,             1, 9, 9, 7, 32'hAA,       32'h22,       0, 0, 32'h99,       0);
        vecs[11] = mk(0, 0, 0,            0, 0, 0,             0, 0, 9, 9, 32'hAA,       32'hAA,       1, 1, 32'hAA,       1);
        vecs[12] = mk(1, 1, 32'h101,      1, 2, 32'h202,       0, 0, 1, 2, 32'h101,      32'h202,      0, 0, 32'h0,        0);
        vecs[13] = mk(0, 0, 0,            0, 0, 0,             0, 0, 1, 2, 32'h101,      32'h202,      0, 0, 32'h101,      0);
        vecs[14] = mk(0, 0, 0,            0, 0, 0,             1, 4, 4, 9, 32'h0,        32'hAA,       0, 1, 32'h0,        0);
        vecs[15] = mk(1, 4, 32'h44,       0, 0, 0,             0, 0, 4, 4, 32'h44,       32'h44,       0, 0, 32'h0,        1);
        vecs[16] = mk(0, 0, 0,            0, 0, 0,             0, 0, 4, 4, 32'h44,       32'h44,       0, 0, 32'h44,       0);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            we0 = vecs[i].we0; wn0 = vecs[i].wn0; d0 = vecs[i].d0;
            we1 = vecs[i].we1; wn1 = vecs[i].wn1; d1 = vecs[i].d1;
            iss_en = vecs[i].iss; iss_rn = vecs[i].iss_rn;
            rn = {vecs[i].rn1, vecs[i].rn0};
            #1;
            chk($sformatf("v%0d_q0", i), qa[31:0], vecs[i].eq0);
            chk($sformatf("v%0d_q1", i), qa[63:32], vecs[i].eq1);
            chk($sformatf("v%0d_rb0", i), {31'h0, rba[0]}, {31'h0, vecs[i].erb0});
            chk($sformatf("v%0d_rb1", i), {31'h0, rba[1]}, {31'h0, vecs[i].erb1});
            chk($sformatf("v%0d_nobyp_q0", i), qb[31:0], vecs[i].eqb0);
            chk($sformatf("v%0d_nobyp_rb0", i), {31'h0, rbb[0]}, {31'h0, vecs[i].erbb0});
        end

        // Reset pulse across an edge carrying a write to r3.
        @(negedge clk);
        idle();
        we0 = 1; wn0 = 5'd3; d0 = 32'h1234; clr = 1;
        @(negedge clk);
        idle();
        clr = 0;
        rn = {5'd9, 5'd3};
        #1;
        chk("midclr_r3", qa[31:0], 32'h0);
        chk("midclr_r9", qa[63:32], 32'h0);
        chk("midclr_rb9", {31'h0, rba[1]}, 32'h0);
        rn = {5'd4, 5'd7};
        #1;
        chk("midclr_r7", qa[31:0], 32'h0);
        chk("midclr_rb4", {31'h0, rba[1]}, 32'h0);

        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        m_busy = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic v0, v1, vi;
            @(negedge clk);
            c_we0 = 1'($urandom); c_wn0 = rnd_addr(); c_d0 = $urandom;
            c_we1 = 1'($urandom); c_wn1 = rnd_addr(); c_d1 = $urandom;
            c_iss_en = 1'($urandom); c_iss_rn = rnd_addr();
            for (int k = 0; k < 4; k++) c_rn[k*6 +: 6] = rnd_addr();
            v0 = c_we0 && (c_wn0 != 0);
            v1 = c_we1 && (c_wn1 != 0);
            vi = c_iss_en && (c_iss_rn != 0);
            #1;
            for (int k = 0; k < 4; k++) begin
                logic [5:0]  a;
                logic [31:0] eq;
                logic        eb;
                a  = c_rn[k*6 +: 6];
                eq = m_mem[a];
                eb = m_busy[a];
                if (a == 0) begin
                    eq = 0; eb = 0;
                end else begin
                    if (v1 && c_wn1 == a) eq = c_d1;
                    else if (v0 && c_wn0 == a) eq = c_d0;
                    if (((v0 && c_wn0 == a) || (v1 && c_wn1 == a)) && !(vi && c_iss_rn == a)) eb = 0;
                end
                chk($sformatf("rand%0d_q%0d", cyc, k), c_q[k*32 +: 32], eq);
                chk($sformatf("rand%0d_rb%0d", cyc, k), {31'h0, c_rbusy[k]}, {31'h0, eb});
            end
            if (v0) begin m_mem[c_wn0] = c_d0; m_busy[c_wn0] = 0; end
            if (v1) begin m_mem[c_wn1] = c_d1; m_busy[c_wn1] = 0; end
            if (vi) m_busy[c_iss_rn] = 1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the CPU's 2-read/1-write register file.
- Provides NREAD combinational read ports and two write ports: port 0 for ALU writeback, port 1 for load writeback.
- Adds optional write-to-read bypass and a per-register busy scoreboard used by the issue stage for load-use interlock.
- Sits between the decode/issue stage and the writeback stage of the MIPS pipeline.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- NREAD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1 register 0 reads as 0, is never written and is never busy.
- BYPASS, 1, when 1 same-cycle write data is forwarded to matching read ports.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  asynchronous reset, active-high.
- rn  in  NREAD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- q  out  NREAD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- rbusy  out  NREAD  busy flag of the addressed register, per read port.
- we0, wn0, d0  in  1/ADDR_W/DATA_W  write port 0 (ALU writeback).
- we1, wn1, d1  in  1/ADDR_W/DATA_W  write port 1 (load writeback).
- iss_en  in  1  issue of an instruction with a pending destination.
- iss_rn  in  ADDR_W  destination register to mark busy.

Behaviour:
- Reset:
  - Decided: one clock; reset is asynchronous and active-high.
  - While clr=1 all registers and all busy bits are 0, q is all-zero, rbusy is all-zero, and writes/issues are ignored.
  - On clr deassertion the first rising edge behaves normally.
  - Reset mid-operation discards any in-flight write.
- Read:
  - Combinational, zero latency.
  - q[k] = mem[rn[k]], except:
    - ZERO_REG=1 and rn[k]=0 -> 0.
    - BYPASS=1 and a valid write to rn[k] this cycle -> that write's data.
- Write:
  - Registered on the rising clk edge.
  - Port p is valid when we_p=1 and (ZERO_REG=0 or wn_p!=0).
- Write collision (both ports valid, wn0==wn1): port 1 wins, for both storage and bypass; port 0's data is dropped.
- Two valid writes to different registers both commit in the same cycle.
- Scoreboard:
  - busy[iss_rn] is set on the edge when iss_en=1.
  - busy[wn_p] is cleared on the edge of any valid write on either port.
  - Set and clear to the same register in one cycle -> set wins (the newer producer is pending).
  - Issue to register 0 with ZERO_REG=1 is ignored.
  - rbusy[k] = busy[rn[k]], forced 0 for register 0 when ZERO_REG=1.
- rbusy bypass: with BYPASS=1, a valid write to rn[k] this cycle forces rbusy[k]=0 unless iss_en targets the same register in the same cycle.
- Read/write same cycle with BYPASS=0: q returns the old value; the new value is visible from the next cycle.
- Address space: every rn/wn value in 0..2**ADDR_W-1 is valid; there is no out-of-range case.

Decomposition:
- Shared package regfile_pkg:
  - default constants DATA_W_DEF=32 and ADDR_W_DEF=5;
  - constant REG_ZERO=0.
- Sub-module regfile_rdport, one per read port, instantiated NREAD times via generate:
  - inputs: address, storage vector, busy vector, both write ports, issue port;
  - implements the zero/bypass/priority selection for q and rbusy.
- Storage, write logic and scoreboard stay in the top module.

Test Plan:
- Reset then read all 32 registers on both ports -> q=0 and rbusy=0 everywhere; pulse clr mid-write of wn0=3, d0=0x1234 -> r3 reads 0 after release.
- Write wn0=5, d0=0xDEADBEEF while rn[0]=5 in the same cycle -> BYPASS=1: q[0]=0xDEADBEEF immediately; BYPASS=0: old value, then 0xDEADBEEF the next cycle.
- Same-cycle writes wn0=wn1=7 with d0=0x11, d1=0x22 -> r7 reads 0x22; bypassed q also 0x22.
- Write wn1=0, d1=0xFFFFFFFF plus iss_en with iss_rn=0 -> r0 reads 0 and rbusy=0 for register 0 (ZERO_REG=1).
- Scoreboard, register 9:
  - iss_en, iss_rn=9 -> rbusy=1 on the next cycle;
  - we1, wn1=9 -> rbusy=0 in the same cycle under bypass, 0 after the edge;
  - simultaneous iss_rn=9 and wn0=9 -> rbusy=1 after the edge.
- NREAD=4, ADDR_W=6 build -> random writes to 64 registers match a reference model on all 4 ports over 10k cycles.
